// File: rtl/alu_frame_pkg.sv
// Shared definitions for the framed ALU command sequencer: FSM state
// encoding, response status bytes and the default frame sync marker.
package alu_frame_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GET_A     = 3'd1,
      S_GET_B     = 3'd2,
      S_GET_OP    = 3'd3,
      S_GET_CHK   = 3'd4,
      S_EXEC      = 3'd5,
      S_SEND_STAT = 3'd6,
      S_SEND_RES  = 3'd7
   } state_t;

   localparam logic [7:0] ST_OK  = 8'hA5;
   localparam logic [7:0] ST_CHK = 8'hE1;
   localparam logic [7:0] ST_OP  = 8'hE2;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

   // Bad opcode has priority over checksum mismatch.
   function automatic logic [7:0] status_byte(input logic op_err, input logic chk_err);
      if (op_err)
         return ST_OP;
      else if (chk_err)
         return ST_CHK;
      else
         return ST_OK;
   endfunction

endpackage

// File: rtl/alu_frame_ctrl_if.sv
// Bus bundle between the frame sequencer, the UART FIFOs and the ALU.
//
// Handshake semantics:
//   RX side: a byte is transferred on a rising edge where o_rd=1; o_rd is
//   only ever raised while i_rx_empty=0 (i_rx_empty acts as inverse valid,
//   o_rd as ready+pop), and i_rx_data is the FIFO head sampled on that edge.
//   TX side: a byte is transferred on a rising edge where o_wr=1; o_wr is
//   only ever raised while i_tx_full=0 (i_tx_full acts as inverse ready),
//   and o_tx_data carries the byte for that same edge.
// o_dbg_state exposes the sequencer FSM state for checkers.
interface alu_frame_ctrl_if #(
   parameter int BUS_SIZE = 8,
   parameter int OP_SIZE  = BUS_SIZE - 2
);
   import alu_frame_pkg::*;

   logic [BUS_SIZE-1:0] i_rx_data;
   logic                i_rx_empty;
   logic                o_rd;
   logic                i_tx_full;
   logic                o_wr;
   logic [BUS_SIZE-1:0] o_tx_data;
   logic [BUS_SIZE-1:0] o_opA;
   logic [BUS_SIZE-1:0] o_opB;
   logic [OP_SIZE-1:0]  o_opCode;
   logic [BUS_SIZE-1:0] i_result;
   logic                o_busy;
   logic                o_timeout;
   state_t              o_dbg_state;

   modport master (
      input  i_rx_data, i_rx_empty, i_tx_full, i_result,
      output o_rd, o_wr, o_tx_data, o_opA, o_opB, o_opCode,
             o_busy, o_timeout, o_dbg_state
   );

   modport slave (
      output i_rx_data, i_rx_empty, i_tx_full, i_result,
      input  o_rd, o_wr, o_tx_data, o_opA, o_opB, o_opCode,
             o_busy, o_timeout, o_dbg_state
   );

endinterface

// File: rtl/alu_frame_ctrl_timer.sv
// Inter-byte timeout counter. Counts enabled cycles, restarts on clear,
// and raises expire_o for one cycle when the count reaches
// TIMEOUT_CYCLES-1 (then restarts on its own).
module frame_timer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Expire detection and next count; clear has priority over counting.
   always_comb begin
      expire_o = en_i & ~clear_i & (cnt_q == LAST);
      cnt_d    = cnt_q;
      if (clear_i || expire_o)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + CW'(1);
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/alu_frame_ctrl.sv
// Framed command sequencer between the UART RX/TX FIFOs and the ALU.
// Hunts for SYNC_BYTE, collects A, B, OP (and CHK when
// ALU_FRAME_CHECKSUM_EN is defined), runs the ALU for one cycle and
// returns a status byte followed by the result byte. A stalled frame is
// dropped after TIMEOUT_CYCLES idle cycles so the stream cannot stay
// misaligned.
module alu_frame_ctrl
   import alu_frame_pkg::*;
#(
   parameter int                  BUS_SIZE       = 8,
   parameter int                  OP_SIZE        = BUS_SIZE - 2,
   parameter logic [BUS_SIZE-1:0] SYNC_BYTE      = BUS_SIZE'(DEFAULT_SYNC_BYTE),
   parameter int                  TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_frame_ctrl_if.master      bus
);

   state_t              state_q, state_d;
   logic [BUS_SIZE-1:0] opa_q, opb_q, status_q, result_q;
   logic [OP_SIZE-1:0]  opcode_q;
   logic [1:0]          op_hi_q;
   logic                timeout_q;
`ifdef ALU_FRAME_CHECKSUM_EN
   logic [BUS_SIZE-1:0] chk_q;
`endif

   logic rx_state, get_state, pop;
   logic tmr_clear, tmr_en, tmr_expire;
   logic op_err, chk_err;

   assign rx_state  = (state_q == S_IDLE) || get_state;
   assign get_state = (state_q == S_GET_A) || (state_q == S_GET_B) ||
                      (state_q == S_GET_OP) || (state_q == S_GET_CHK);
   assign pop       = rx_state & ~bus.i_rx_empty;

   // The timer only runs while waiting for the next byte of a frame.
   assign tmr_clear = pop | ~get_state;
   assign tmr_en    = get_state & ~pop;

   assign op_err = |op_hi_q;
`ifdef ALU_FRAME_CHECKSUM_EN
   assign chk_err = (chk_q != (opa_q ^ opb_q ^ {op_hi_q, opcode_q}));
`else
   assign chk_err = 1'b0;
`endif

   frame_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (tmr_clear),
      .en_i     (tmr_en),
      .expire_o (tmr_expire)
   );

   // FSM next state: a pop always wins over a same-cycle timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:
            if (pop && (bus.i_rx_data == SYNC_BYTE))
               state_d = S_GET_A;
         S_GET_A:
            if (pop)             state_d = S_GET_B;
            else if (tmr_expire) state_d = S_IDLE;
         S_GET_B:
            if (pop)             state_d = S_GET_OP;
            else if (tmr_expire) state_d = S_IDLE;
         S_GET_OP:
`ifdef ALU_FRAME_CHECKSUM_EN
            if (pop)             state_d = S_GET_CHK;
`else
            if (pop)             state_d = S_EXEC;
`endif
            else if (tmr_expire) state_d = S_IDLE;
         S_GET_CHK:
            if (pop)             state_d = S_EXEC;
            else if (tmr_expire) state_d = S_IDLE;
         S_EXEC:
            state_d = S_SEND_STAT;
         S_SEND_STAT:
            if (!bus.i_tx_full)  state_d = S_SEND_RES;
         S_SEND_RES:
            if (!bus.i_tx_full)  state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Operand capture on pops, status/result latch in EXEC, timeout pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         opa_q     <= '0;
         opb_q     <= '0;
         opcode_q  <= '0;
         op_hi_q   <= '0;
         status_q  <= '0;
         result_q  <= '0;
         timeout_q <= 1'b0;
`ifdef ALU_FRAME_CHECKSUM_EN
         chk_q     <= '0;
`endif
      end else begin
         timeout_q <= tmr_expire;
         if (pop) begin
            case (state_q)
               S_GET_A:  opa_q <= bus.i_rx_data;
               S_GET_B:  opb_q <= bus.i_rx_data;
               S_GET_OP: begin
                  opcode_q <= bus.i_rx_data[OP_SIZE-1:0];
                  op_hi_q  <= bus.i_rx_data[BUS_SIZE-1:OP_SIZE];
               end
`ifdef ALU_FRAME_CHECKSUM_EN
               S_GET_CHK: chk_q <= bus.i_rx_data;
`endif
               default: ;
            endcase
         end
         if (state_q == S_EXEC) begin
            status_q <= BUS_SIZE'(status_byte(op_err, chk_err));
            result_q <= (op_err || chk_err) ? '0 : bus.i_result;
         end
      end
   end

   // Output decode from the state register and FIFO flags.
   always_comb begin
      bus.o_tx_data = '0;
      if (state_q == S_SEND_STAT)
         bus.o_tx_data = status_q;
      else if (state_q == S_SEND_RES)
         bus.o_tx_data = result_q;
   end

   assign bus.o_rd        = pop;
   assign bus.o_wr        = ((state_q == S_SEND_STAT) || (state_q == S_SEND_RES)) & ~bus.i_tx_full;
   assign bus.o_opA       = opa_q;
   assign bus.o_opB       = opb_q;
   assign bus.o_opCode    = opcode_q;
   assign bus.o_busy      = (state_q != S_IDLE);
   assign bus.o_timeout   = timeout_q;
   assign bus.o_dbg_state = state_q;

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Directed bench for alu_frame_ctrl: RX FIFO model (byte queue), TX capture
// queue, small ALU stand-in, scoreboard of expected TX bytes.
// Build with ALU_FRAME_CHECKSUM_EN to exercise the checksum frame format.
module tb_alu_frame_ctrl;
   import alu_frame_pkg::*;

   localparam int TO = 20;

   logic clk;
   logic reset;

   alu_frame_ctrl_if #(.BUS_SIZE(8), .OP_SIZE(6)) bus();

   alu_frame_ctrl #(
      .BUS_SIZE       (8),
      .OP_SIZE        (6),
      .SYNC_BYTE      (8'h55),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ALU stand-in ----------------
   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         default: return 8'h00;
      endcase
   endfunction

   assign bus.i_result = alu_model(bus.o_opA, bus.o_opB, bus.o_opCode);

   // ---------------- bench state ----------------
   logic [7:0] rx_q[$];
   logic [7:0] tx_got[$];
   int         tx_edge_q[$];
   logic [7:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_pop_edge = -1;
   int timeout_cnt   = 0;
   int timeout_edge  = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic update_rx();
      bus.i_rx_empty = (rx_q.size() == 0);
      bus.i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_q.push_back(b);
      update_rx();
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      push_byte(8'h55);
      push_byte(a);
      push_byte(b);
      push_byte(op);
`ifdef ALU_FRAME_CHECKSUM_EN
      push_byte(a ^ b ^ op);
`endif
   endtask

   task automatic expect_tx(input logic [7:0] st, input logic [7:0] res);
      exp_q.push_back(st);
      exp_q.push_back(res);
   endtask

   // One clock: sample at negedge, apply FIFO effects just after posedge.
   task automatic step();
      logic       rd, wr;
      logic [7:0] txd;
      @(negedge clk);
      rd  = bus.o_rd;
      wr  = bus.o_wr;
      txd = bus.o_tx_data;
      if (bus.o_timeout) begin
         timeout_cnt++;
         timeout_edge = cyc;
      end
      if (rd) check("pop_nonempty", 32'(rx_q.size() != 0), 32'd1);
      if (wr) check("push_not_full", 32'(bus.i_tx_full), 32'd0);
      @(posedge clk);
      cyc++;
      #1;
      if (rd && rx_q.size() != 0) begin
         void'(rx_q.pop_front());
         last_pop_edge = cyc;
      end
      if (wr) begin
         tx_got.push_back(txd);
         tx_edge_q.push_back(cyc);
      end
      update_rx();
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k;
      k = 0;
      while (tx_got.size() < n && k < budget) begin
         step();
         k++;
      end
      check("tx_arrived", 32'(tx_got.size()), 32'(n));
   endtask

   // Scoreboard: pushed bytes must match the expected queue in order.
   task automatic compare_tx();
      while (exp_q.size() != 0 && tx_got.size() != 0)
         check("tx_byte", 32'(tx_got.pop_front()), 32'(exp_q.pop_front()));
      check("tx_extra", 32'(tx_got.size()), 32'd0);
      exp_q.delete();
      tx_edge_q.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n_last;
      int p;
      int k;

      reset          = 1'b0;
      bus.i_tx_full  = 1'b0;
      update_rx();

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rd",      32'(bus.o_rd),        32'd0);
      check("rst_wr",      32'(bus.o_wr),        32'd0);
      check("rst_txdata",  32'(bus.o_tx_data),   32'd0);
      check("rst_opA",     32'(bus.o_opA),       32'd0);
      check("rst_opB",     32'(bus.o_opB),       32'd0);
      check("rst_opCode",  32'(bus.o_opCode),    32'd0);
      check("rst_busy",    32'(bus.o_busy),      32'd0);
      check("rst_timeout", 32'(bus.o_timeout),   32'd0);
      check("rst_state",   32'(bus.o_dbg_state), 32'(S_IDLE));
      @(posedge clk);
      #1 reset = 1'b1;

      // Basic add frame, latency of status/result pushes
      send_frame(8'h07, 8'h03, 8'h20);
      expect_tx(8'hA5, 8'h0A);
      wait_tx(2, 40);
      n_last = last_pop_edge;
      if (tx_edge_q.size() >= 2) begin
         check("lat_status", 32'(tx_edge_q[0] - n_last), 32'd2);
         check("lat_result", 32'(tx_edge_q[1] - n_last), 32'd3);
      end
      compare_tx();
      check("add_opA",    32'(bus.o_opA),       32'h07);
      check("add_opB",    32'(bus.o_opB),       32'h03);
      check("add_opCode", 32'(bus.o_opCode),    32'h20);
      check("add_state",  32'(bus.o_dbg_state), 32'(S_IDLE));

      // Junk before sync is dropped; next pop right after the result push
      push_byte(8'h12);
      push_byte(8'h34);
      send_frame(8'h01, 8'h01, 8'h20);
      step();
      check("ready_pop_edge", 32'(last_pop_edge), 32'(n_last + 4));
      expect_tx(8'hA5, 8'h02);
      wait_tx(2, 60);
      compare_tx();
      check("junk_no_timeout", 32'(timeout_cnt), 32'd0);
      check("junk_rx_drained", 32'(rx_q.size()),  32'd0);

      // Bad opcode high bits
      send_frame(8'h07, 8'h03, 8'hE0);
      expect_tx(8'hE2, 8'h00);
      wait_tx(2, 40);
      compare_tx();
      check("badop_opCode", 32'(bus.o_opCode), 32'h20);

      // Inter-byte timeout
      push_byte(8'h55);
      push_byte(8'h09);
      k = 0;
      while (rx_q.size() != 0 && k < 10) begin
         step();
         k++;
      end
      p = last_pop_edge;
      check("to_busy_mid", 32'(bus.o_busy), 32'd1);
      repeat (TO + 5) step();
      check("to_pulses",  32'(timeout_cnt),        32'd1);
      check("to_edge",    32'(timeout_edge),       32'(p + TO));
      check("to_busy",    32'(bus.o_busy),         32'd0);
      check("to_no_tx",   32'(tx_got.size()),      32'd0);
      check("to_opA",     32'(bus.o_opA),          32'h09);
      check("to_state",   32'(bus.o_dbg_state),    32'(S_IDLE));
      send_frame(8'h02, 8'h02, 8'h20);
      expect_tx(8'hA5, 8'h04);
      wait_tx(2, 40);
      compare_tx();

      // TX full stall, no timeout while sending
      bus.i_tx_full = 1'b1;
      send_frame(8'h05, 8'h06, 8'h20);
      repeat (60) step();
      check("full_no_tx", 32'(tx_got.size()),      32'd0);
      check("full_wr",    32'(bus.o_wr),           32'd0);
      check("full_state", 32'(bus.o_dbg_state),    32'(S_SEND_STAT));
      check("full_busy",  32'(bus.o_busy),         32'd1);
      check("full_no_to", 32'(timeout_cnt),        32'd1);
      bus.i_tx_full = 1'b0;
      expect_tx(8'hA5, 8'h0B);
      wait_tx(2, 20);
      compare_tx();

      // Sync byte used as operand data; other ALU ops
      send_frame(8'h55, 8'h55, 8'h25);
      expect_tx(8'hA5, 8'h55);
      wait_tx(2, 40);
      compare_tx();
      check("sync_data_opA", 32'(bus.o_opA), 32'h55);
      send_frame(8'h09, 8'h04, 8'h22);
      send_frame(8'hF0, 8'h3C, 8'h24);
      expect_tx(8'hA5, 8'h05);
      expect_tx(8'hA5, 8'h30);
      wait_tx(4, 80);
      compare_tx();

`ifdef ALU_FRAME_CHECKSUM_EN
      // Checksum mismatch
      push_byte(8'h55);
      push_byte(8'h07);
      push_byte(8'h03);
      push_byte(8'h20);
      push_byte(8'h00);
      expect_tx(8'hE1, 8'h00);
      wait_tx(2, 40);
      compare_tx();
`endif

      // Reset mid-frame
      push_byte(8'h55);
      push_byte(8'h11);
      push_byte(8'h22);
      k = 0;
      while (rx_q.size() != 0 && k < 10) begin
         step();
         k++;
      end
      check("mid_state", 32'(bus.o_dbg_state), 32'(S_GET_OP));
      reset = 1'b0;
      #2;
      check("mid_rst_opA",    32'(bus.o_opA),       32'd0);
      check("mid_rst_opB",    32'(bus.o_opB),       32'd0);
      check("mid_rst_opCode", 32'(bus.o_opCode),    32'd0);
      check("mid_rst_busy",   32'(bus.o_busy),      32'd0);
      check("mid_rst_state",  32'(bus.o_dbg_state), 32'(S_IDLE));
      check("mid_rst_wr",     32'(bus.o_wr),        32'd0);
      check("mid_rst_txdata", 32'(bus.o_tx_data),   32'd0);
      rx_q.delete();
      update_rx();
      @(posedge clk);
      #1 reset = 1'b1;
      send_frame(8'h03, 8'h04, 8'h20);
      expect_tx(8'hA5, 8'h07);
      wait_tx(2, 40);
      compare_tx();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_frame_ctrl.md
# alu_frame_ctrl

Framed command sequencer between the UART RX/TX FIFOs and the combinational ALU. Hunts for a sync byte, collects operand A, operand B and opcode (plus optional checksum), drives the ALU, and returns a status byte followed by the result byte to the TX FIFO. Replaces free-running byte counting with framing, validation and an inter-byte timeout, so a lost byte cannot permanently misalign the operand stream.

## Interface
- BUS_SIZE, 8, data/operand width
- OP_SIZE, 6, opcode width (BUS_SIZE-2)
- SYNC_BYTE, 8'h55, frame start marker
- TIMEOUT_CYCLES, 1000000, max idle cycles between bytes inside a frame (>=2)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- i_rx_data  in  BUS_SIZE  RX FIFO head byte, valid when i_rx_empty=0
- i_rx_empty  in  1  RX FIFO empty
- o_rd  out  1  RX pop strobe, one cycle per byte consumed
- i_tx_full  in  1  TX FIFO full
- o_wr  out  1  TX push strobe
- o_tx_data  out  BUS_SIZE  byte pushed when o_wr=1
- o_opA, o_opB  out  BUS_SIZE  registered ALU operands
- o_opCode  out  OP_SIZE  registered ALU opcode
- i_result  in  BUS_SIZE  ALU combinational result
- o_busy  out  1  high in every state except IDLE
- o_timeout  out  1  one-cycle pulse on frame abort by timeout

## Operation
- States: IDLE, GET_A, GET_B, GET_OP, GET_CHK (only with macro), EXEC, SEND_STAT, SEND_RES.
- Pop rule: o_rd = 1 exactly when state is IDLE/GET_* and i_rx_empty=0; byte captured on same edge. Never pops when empty; never pops outside those states.
- IDLE: popped byte == SYNC_BYTE -> GET_A; any other byte discarded, stay IDLE.
- GET_A/GET_B: popped byte loads o_opA/o_opB, advance.
- GET_OP: low OP_SIZE bits load o_opCode; upper 2 bits kept in op_hi; -> GET_CHK or EXEC.
- EXEC (one cycle): latch i_result into result register; compute status: 8'hE2 if op_hi != 0, else 8'hE1 on checksum mismatch, else 8'hA5. On any error result register = 8'h00. -> SEND_STAT.
- SEND_STAT: o_wr=1, o_tx_data=status when i_tx_full=0; stall otherwise. -> SEND_RES after push.
- SEND_RES: same rule with result byte; after push -> IDLE.
- Timeout: counter cleared on every pop and in IDLE/EXEC/SEND_*; increments in GET_* while nothing popped. On reaching TIMEOUT_CYCLES-1: pulse o_timeout, -> IDLE, no response, operand registers keep last values.
- SYNC_BYTE inside a frame is data, not a resync.

## Timing
- Reset values: o_rd=0, o_wr=0, o_tx_data=0, o_opA=0, o_opB=0, o_opCode=0, o_busy=0, o_timeout=0, state IDLE, counter 0.
- o_rd combinational from state and i_rx_empty; all other outputs registered-state derived, o_wr = (SEND_*) & ~i_tx_full.
- Back-to-back bytes accepted at one per cycle.
- Last frame byte popped at edge N: EXEC during cycle N+1, status pushed at edge N+2 earliest, result at N+3, IDLE (ready to pop) in cycle N+3... next pop possible edge N+4.
- Full TX FIFO stalls indefinitely; no timeout in SEND_*.
- Timeout and a pop in the same cycle: pop wins, counter clears.
- Reset low mid-frame or mid-send: immediate return to reset values, partial response abandoned.

## Configuration
- ALU_FRAME_CHECKSUM_EN defined: frame is SYNC,A,B,OP,CHK; GET_CHK pops CHK; mismatch when CHK != A^B^OP (full 8-bit OP byte) -> status 8'hE1.
- Undefined: GET_CHK absent, frame is SYNC,A,B,OP; status 8'hE1 never produced.

## Structure
- Shared package alu_frame_pkg: state enum encoding, status constants (ST_OK=8'hA5, ST_CHK=8'hE1, ST_OP=8'hE2), default SYNC_BYTE.
- One sub-module: frame_timer (clear, enable, TIMEOUT_CYCLES parameter, one-cycle expire output), width $clog2(TIMEOUT_CYCLES).

## Test plan
- RX 55,07,03,20 (ALU add, result 0A) -> TX A5,0A; o_opA=07, o_opB=03, o_opCode=20.
- Junk 12,34 then 55,01,01,20 -> junk popped and dropped, TX A5,02, no timeout.
- 55,07,03,E0 (op_hi=11) -> TX E2,00.
- 55,07 then RX empty for TIMEOUT_CYCLES -> o_timeout single pulse, o_busy falls, no TX push; following 55,02,02,20 -> A5,04.
- i_tx_full held high 50 cycles after EXEC -> o_wr stays 0, state holds, both bytes pushed after release in order.
- With ALU_FRAME_CHECKSUM_EN: 55,07,03,20,24 -> A5,0A; 55,07,03,20,00 -> E1,00; reset pulse mid-frame -> all outputs zero, next frame processed normally.
